// File: rtl/mine_pkg.sv
// Shared board geometry, LFSR constants, placer state encoding and cell indexing
// for the busca_minas mine placer.
package mine_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned CELLS = ROWS * COLS;

  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} placer_state_t;

  typedef logic [5:0] cell_idx_t;

  // Flat map index: row*COLS + col with COLS a power of two
  function automatic cell_idx_t cell_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit free-running Fibonacci LFSR; a zero SEED is replaced by 8'h01 so the
// register can never lock up in the all-zero state.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5,
  parameter logic [7:0] TAPS = 8'hB8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & TAPS)};
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/mine_placer.sv
// Places target distinct mines on the board from LFSR candidates, rejecting duplicates.
// Optional macro MINE_PLACER_SAFE_CELL_EN adds a guaranteed-empty safe cell.
module mine_placer
  import mine_pkg::*;
#(
  parameter int unsigned ROWS      = mine_pkg::ROWS,
  parameter int unsigned COLS      = mine_pkg::COLS,
  parameter int unsigned MAX_MINES = 15,
  parameter logic [7:0]  SEED      = mine_pkg::DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             total_mines,
`ifdef MINE_PLACER_SAFE_CELL_EN
  input  logic [2:0]             safe_row,
  input  logic [2:0]             safe_col,
`endif
  output logic [2:0]             random_row,
  output logic [2:0]             random_col,
  output logic                   place_valid,
  output logic [ROWS*COLS-1:0]   mine_map,
  output logic [3:0]             mine_count,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NCELLS = ROWS * COLS;
`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam int unsigned CAP = CELLS - 1;
`else
  localparam int unsigned CAP = CELLS;
`endif
  localparam int unsigned MAX_A   = (MAX_MINES < CAP) ? MAX_MINES : CAP;
  localparam int unsigned MAX_EFF = (MAX_A < 15) ? MAX_A : 15;

  logic [7:0]        lfsr_q;
  logic [1:0]        lfsr_unused;
  cell_idx_t         cand_c;
  logic [3:0]        target_c;
  logic              safe_hit_c;
  logic              accept_c;

  placer_state_t     state_q;
  logic [3:0]        target_q;
  logic [NCELLS-1:0] map_q;
  logic [3:0]        count_q;
  logic [2:0]        row_q;
  logic [2:0]        col_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  lfsr8 #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign lfsr_unused = lfsr_q[7:6];
  assign cand_c      = cell_idx(lfsr_q[5:3], lfsr_q[2:0]);
  assign target_c    = ({28'd0, total_mines} > MAX_EFF) ? 4'(MAX_EFF) : total_mines;

`ifdef MINE_PLACER_SAFE_CELL_EN
  cell_idx_t safe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      safe_q <= '0;
    end else if (start && (state_q == IDLE || state_q == DONE)) begin
      safe_q <= cell_idx(safe_row, safe_col);
    end
  end

  assign safe_hit_c = (cand_c == safe_q);
`else
  assign safe_hit_c = 1'b0;
`endif

  // A candidate is taken only if its cell is empty and not the protected cell
  assign accept_c = (state_q == PLACE) && !map_q[cand_c] && !safe_hit_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      map_q    <= '0;
      count_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= CLEAR;
            target_q <= target_c;
            busy_q   <= 1'b1;
          end
        end
        CLEAR: begin
          map_q   <= '0;
          count_q <= '0;
          if (target_q == 4'd0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= PLACE;
          end
        end
        PLACE: begin
          if (accept_c) begin
            map_q[cand_c] <= 1'b1;
            count_q       <= count_q + 4'd1;
            row_q         <= cand_c[5:3];
            col_q         <= cand_c[2:0];
            valid_q       <= 1'b1;
            if ((count_q + 4'd1) == target_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_q  <= CLEAR;
            target_q <= target_c;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign random_row  = row_q;
  assign random_col  = col_q;
  assign place_valid = valid_q;
  assign mine_map    = map_q;
  assign mine_count  = count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mine_placer.sv
// Directed, table-driven bench for mine_placer with a lockstep LFSR model and pulse scoreboard.
module tb_mine_placer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  total_mines;
`ifdef MINE_PLACER_SAFE_CELL_EN
  logic [2:0]  safe_row;
  logic [2:0]  safe_col;
`endif
  logic [2:0]  random_row;
  logic [2:0]  random_col;
  logic        place_valid;
  logic [63:0] mine_map;
  logic [3:0]  mine_count;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mine_placer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .total_mines (total_mines),
`ifdef MINE_PLACER_SAFE_CELL_EN
    .safe_row    (safe_row),
    .safe_col    (safe_col),
`endif
    .random_row  (random_row),
    .random_col  (random_col),
    .place_valid (place_valid),
    .mine_map    (mine_map),
    .mine_count  (mine_count),
    .busy        (busy),
    .done        (done)
  );

  // Golden LFSR: x^8+x^6+x^5+x^4+1, shift left, seed A5
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Pulse scoreboard: coordinate must equal the previous cycle's candidate and never repeat
  logic [5:0]  prev_cand  = '0;
  logic        prev_busy  = 1'b0;
  logic [63:0] seen_map   = '0;
  int          pulse_cnt  = 0;
  int          coord_err  = 0;
  int          dup_err    = 0;
  wire  [5:0]  pulse_idx  = {random_row, random_col};

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      seen_map  = '0;
      pulse_cnt = 0;
    end
    if (place_valid === 1'b1) begin
      pulse_cnt++;
      if (pulse_idx !== prev_cand) coord_err++;
      if (seen_map[pulse_idx]) dup_err++;
      seen_map[pulse_idx] = 1'b1;
    end
    prev_busy = busy;
    prev_cand = m_lfsr[5:0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Accepted start, bounded wait for done, then post-run map/count/scoreboard checks
  task automatic run_board(input logic [3:0] tm, input int exp_n, input int exact_lat, input string tag);
    int          cyc;
    logic [63:0] map_at_done;
    total_mines = tm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy_in_clear"}, 64'(busy), 64'd1);
    check({tag, "_done_dropped"}, 64'(done), 64'd0);
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) check({tag, "_map_cleared"}, mine_map, 64'd0);
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    if (exact_lat >= 0) check({tag, "_latency"}, 64'(cyc), 64'(exact_lat));
    else                check({tag, "_latency_le_257"}, 64'(cyc <= 257), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    map_at_done = mine_map;
    repeat (5) @(negedge clk);
    check({tag, "_map_held"}, mine_map, map_at_done);
    check({tag, "_done_held"}, 64'(done), 64'd1);
    check({tag, "_pulses"}, 64'(pulse_cnt), 64'(exp_n));
    check({tag, "_mine_count"}, 64'(mine_count), 64'(exp_n));
    check({tag, "_popcount"}, 64'($countones(mine_map)), 64'(exp_n));
    check({tag, "_map_vs_pulses"}, mine_map, seen_map);
    check({tag, "_coord_err"}, 64'(coord_err), 64'd0);
    check({tag, "_dup_err"}, 64'(dup_err), 64'd0);
  endtask

  typedef struct {
    logic [3:0] tm;
    int         exp_n;
    int         exact_lat;
    string      tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int np;
    int cyc;

    vecs[0] = '{4'd5,  5,  -1, "basic5"};
    vecs[1] = '{4'd0,  0,   2, "zero"};
    vecs[2] = '{4'd15, 15, -1, "max15"};
    vecs[3] = '{4'd10, 10, -1, "b2b10"};
    vecs[4] = '{4'd1,  1,  -1, "one"};
    vecs[5] = '{4'd7,  7,  -1, "seven"};

    rst = 1'b1;
    start = 1'b0;
    total_mines = '0;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safe_row = '0;
    safe_col = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_map", mine_map, 64'd0);
    check("rst_count", 64'(mine_count), 64'd0);
    check("rst_row_col", 64'({random_row, random_col}), 64'd0);
    check("rst_valid_busy_done", 64'({place_valid, busy, done}), 64'd0);
    check("rst_state_idle", 64'(dut.state_q), 64'd0);
    check("rst_lfsr_seed", 64'(dut.u_lfsr.q), 64'hA5);

    repeat (10) @(negedge clk);
    check("lfsr_10_free", 64'(dut.u_lfsr.q), 64'(m_lfsr));
    check("idle_no_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_board(vecs[i].tm, vecs[i].exp_n, vecs[i].exact_lat, vecs[i].tag);
    end

    // start and total_mines changes while busy must be ignored
    total_mines = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ign_busy_mid", 64'(busy), 64'd1);
    total_mines = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_done_seen", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    check("ign_count_15", 64'(mine_count), 64'd15);
    check("ign_pulses_15", 64'(pulse_cnt), 64'd15);

    // Reset after the third pulse discards the partial board
    total_mines = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    np = 0;
    cyc = 0;
    while (np < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (place_valid === 1'b1) np++;
    end
    check("rst_mid_three_pulses", 64'(np), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_map", mine_map, 64'd0);
    check("rst_mid_count", 64'(mine_count), 64'd0);
    check("rst_mid_flags", 64'({place_valid, busy, done}), 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'd0);
    repeat (5) @(negedge clk);
    check("rst_mid_stays_idle", 64'({busy, mine_count}), 64'd0);
    check("rst_mid_lfsr", 64'(dut.u_lfsr.q), 64'(m_lfsr));

    run_board(4'd4, 4, -1, "post_rst4");

`ifdef MINE_PLACER_SAFE_CELL_EN
    safe_row = 3'd0;
    safe_col = 3'd0;
    for (int r = 0; r < 50; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      run_board(4'd15, 15, -1, "safe");
      check("safe_cell_empty", 64'(mine_map[0]), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
- Upstream stage of busca_minas: generates pseudo-random board coordinates and places exactly total_mines distinct mines on the 8x8 board before play begins.
- Drives random_row/random_col, one coordinate per accepted placement, and holds the resulting 64-bit mine map for the game core.
- Built around a free-running LFSR plus a placement FSM that rejects duplicate cells.

Parameters:
- ROWS, 8, board rows; fixed power of two, row index width 3.
- COLS, 8, board columns; fixed power of two, column index width 3.
- MAX_MINES, 15, upper clamp on the requested mine count (1..15).
- SEED, 8'hA5, LFSR reset value; if 0, 8'h01 is used instead.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle request to build a new board.
- total_mines, in, 4, requested mine count; sampled on an accepted start.
- random_row, out, 3, row of the most recently placed mine.
- random_col, out, 3, column of the most recently placed mine.
- place_valid, out, 1, one-cycle pulse per new mine; random_row/col valid in that cycle.
- mine_map, out, 64, bit {row,col} = 1 marks a mine; index = row*COLS+col.
- mine_count, out, 4, number of mines placed so far.
- busy, out, 1, high in CLEAR and PLACE.
- done, out, 1, high in DONE; held until the next accepted start or rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, LFSR=SEED (or 8'h01 if SEED=0).
  - mine_map=0, mine_count=0, random_row=0, random_col=0.
  - place_valid=0, busy=0, done=0.
  - Reset mid-PLACE abandons the board entirely; no partial map is retained.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255.
  - Advances every cycle in every state except reset, so player timing adds entropy.
  - Candidate cell: row = lfsr[5:3], col = lfsr[2:0].
- FSM:
  - IDLE: start=1 -> CLEAR; latch target = min(total_mines, MAX_MINES).
  - CLEAR: one cycle; mine_map<=0, mine_count<=0; busy=1.
    - target==0 -> DONE.
    - Otherwise -> PLACE.
  - PLACE, each cycle:
    - If mine_map[cand]==0: set the bit, mine_count<=mine_count+1, random_row/col<=cand, place_valid=1 on the next cycle (registered).
    - If the cell is already occupied: skip; no pulse, no change.
    - When mine_count+accept == target -> DONE.
  - DONE: done=1, busy=0.
    - start=1 -> CLEAR, re-latching total_mines.
- start is ignored in CLEAR and PLACE; no queuing.
- Bound: the period-255 LFSR visits every 6-bit cell value (cell 0 three times, all others four times). PLACE therefore finishes within 255 cycles of entry for any target <= 64. Total worst case is start -> done <= 257 cycles.
- Arithmetic: mine_count is 4 bits and never exceeds the target (<=15), so no wrap.
- mine_map, mine_count and random_row/col hold their values in DONE and IDLE.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: MINE_PLACER_SAFE_CELL_EN.
- With the macro defined:
  - Adds inputs safe_row[2:0] and safe_col[2:0], sampled with start.
  - A candidate equal to the safe cell is rejected like an occupied cell, guaranteeing a safe first click.
  - Target is clamped to min(total_mines, MAX_MINES, 63).
- Without the macro: no extra ports, and every cell is eligible.

Decomposition:
- Package mine_pkg:
  - ROWS, COLS, CELLS=64.
  - LFSR_TAPS=8'hB8 and the default seed.
  - typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} placer_state_t.
  - typedef logic [5:0] cell_idx_t.
  - Function cell_idx(row, col).
- Sub-module lfsr8: parameters SEED and TAPS; ports clk, rst, q[7:0]; zero-seed guard inside.
- mine_placer instantiates lfsr8 and contains the FSM, map register and counter.

Test Plan:
- Reset: rst high 1 cycle -> all outputs 0, state IDLE; after 10 free cycles, lfsr8 q matches the golden model from 8'hA5.
- Basic placement: start with total_mines=5 -> exactly 5 place_valid pulses, popcount(mine_map)=5, mine_count=5, done=1 within 257 cycles; every pulsed coordinate's bit is set in the map.
- Zero mines: total_mines=0 -> done 2 cycles after start, mine_map=0, no place_valid pulse.
- Max and duplicates: total_mines=15 -> 15 distinct coordinates; the scoreboard flags any repeat; back-to-back start in DONE with total_mines=10 -> map cleared, then popcount 10.
- Reset mid-operation: rst asserted after the 3rd pulse of total_mines=15 -> map 0, count 0, IDLE; start ignored while busy (no re-latch; total_mines change mid-PLACE has no effect).
- With MINE_PLACER_SAFE_CELL_EN: safe cell (0,0), total_mines=15, 50 runs at varied start times -> mine_map[0] never set, popcount always 15.
